cfg_master: RTL and testbench
=============================

Name: cfg_master

Overview:
- Bench-side configuration UART master for the cbc digital core.
- On request it serializes a 24-bit command frame onto TX_C as three 8N1 bytes.
- It also receives the core's 2-byte response on RX_C and presents it as a 16-bit word with a ready flag.
- It stands in for the host PC on the config link (core RX_C/TX_C).

Parameters:
- BIT_CLKS, 434, clock cycles per UART bit (minimum 4).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-high (asserted = 1), sampled on rising clk
- cmd_data  in  24  command frame to send; {cmd[23:16], data[15:0]}
- snd_frm  in  1  single-cycle request to start sending cmd_data
- TX_C  out  1  serial out to core's config RX; idle high
- RX_C  in  1  serial in from core's config TX; asynchronous
- resp  out  16  last complete response word
- rsp_rdy  out  1  response-valid flag

Behaviour:
- Reset values: TX_C=1, resp=0, rsp_rdy=0; TX and RX FSMs go to IDLE; all counters clear.
- Reset mid-transfer aborts immediately; TX_C=1 from the cycle after reset is sampled.
- Frame format: 8N1, i.e. start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit is held exactly BIT_CLKS cycles.
  - Bytes go back-to-back with no idle gap.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE + snd_frm=1: latch cmd_data, clear byte index, enter START next cycle.
  - Byte order: cmd_data[23:16], then [15:8], then [7:0].
  - After the STOP of byte 2, return to IDLE.
  - A frame lasts exactly 30*BIT_CLKS cycles from the first START cycle.
- snd_frm while TX is not IDLE is ignored. The latched data is unaffected and no queueing occurs.
- Accepting snd_frm also does two things on the RX side:
  - clears rsp_rdy;
  - resets the RX byte index to 0, discarding any partially received response.
- RX input: RX_C passes through a 2-flop synchronizer before any use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a high-to-low transition on the synchronized line enters START.
  - START: at BIT_CLKS/2 the line is resampled. If high, it is a false start and the FSM returns to IDLE. If low, enter DATA.
  - DATA: 8 samples, each BIT_CLKS apart (mid-bit), shifted in LSB first.
  - STOP: sampled mid-bit. If 1, the byte is accepted. If 0 (framing error), the byte is discarded and the RX byte index resets to 0.
  - After STOP the FSM returns to IDLE and needs a fresh falling edge to start the next byte.
- Response assembly:
  - The first accepted byte goes to resp_hi, the second to resp_lo.
  - On the second byte, resp <= {resp_hi, byte} and rsp_rdy is set on the same edge.
  - resp updates only on the second byte and holds until the next complete response.
- rsp_rdy is a level flag. It stays 1 until the next accepted snd_frm or reset.
  - If a new response completes while rsp_rdy=1, resp updates and rsp_rdy stays 1.
- TX and RX are fully independent, so full-duplex operation is allowed.

Decomposition:
- Shared package cfg_pkg holds:
  - default BIT_CLKS;
  - response constants POSACK=16'h0A5A and NEGACK=16'h05A5;
  - command-field positions CMD_HI=23, CMD_LO=16.
- One natural sub-module: cfg_uart_rx_byte. It covers the synchronizer, the start-validation FSM and the byte shift register, and outputs byte[7:0], byte_vld and frm_err.
- The TX path and response assembly stay in cfg_master.

Test Plan (BIT_CLKS=16):
- Reset: hold rst_n=1 for 2 cycles, then release.
  - Expect TX_C=1, resp=0, rsp_rdy=0.
  - Expect TX_C to stay high for 1000 cycles.
- Send frame: cmd_data=24'hA51234 with a 1-cycle snd_frm.
  - TX_C must carry bytes A5, 12, 34 in that order, LSB first, each bit 16 cycles.
  - The transfer takes 480 cycles in total, after which TX_C=1.
- Response: drive RX_C with bytes 0x0A then 0x5A at 16 cycles/bit.
  - After the second stop-bit sample, expect resp=16'h0A5A and rsp_rdy=1.
  - A following snd_frm clears rsp_rdy.
- Busy ignore: pulse snd_frm with 24'hFFFFFF at cycle 100 of a transfer of 24'h000000.
  - The transmitted bytes must stay 00, 00, 00.
  - No second frame may follow.
- False start and framing error, two cases on RX_C:
  - A 5-cycle low glitch must produce no byte and no resp change.
  - A byte 0x05 with stop bit 0, followed by 0x0A, 0x5A, must give resp=16'h0A5A. The bad byte is discarded.
- Mid-frame reset: assert rst_n at cycle 200 of a frame.
  - Expect TX_C=1 from the next cycle and no further transitions.
  - Expect rsp_rdy=0.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared constants and FSM state encoding for the bench-side config UART master.
package cfg_pkg;

    localparam int          BIT_CLKS_DEF = 434;
    localparam logic [15:0] POSACK       = 16'h0A5A;
    localparam logic [15:0] NEGACK       = 16'h05A5;
    localparam int          CMD_HI       = 23;
    localparam int          CMD_LO       = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_st_e;

endpackage

// File: rtl/cfg_uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit start validation, LSB-first shift.
module cfg_uart_rx_byte
    import cfg_pkg::*;
#(
    parameter int BIT_CLKS = BIT_CLKS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       byte_vld,
    output logic       frm_err
);

    localparam int             CW   = $clog2(BIT_CLKS);
    localparam logic [CW-1:0]  LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0]  HALF = CW'(BIT_CLKS / 2 - 1);

    uart_st_e      st, st_nxt;
    logic          sync1, sync2, prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          cnt_rst, do_shift, vld_d, err_d;

    assign rx_data = shreg;

    always_comb begin
        st_nxt   = st;
        cnt_rst  = 1'b0;
        do_shift = 1'b0;
        vld_d    = 1'b0;
        err_d    = 1'b0;
        case (st)
            ST_IDLE: begin
                cnt_rst = 1'b1;
                if (prev && !sync2) st_nxt = ST_START;
            end
            // Resample half a bit in; a high line means the edge was a glitch.
            ST_START: begin
                if (cnt == HALF) begin
                    cnt_rst = 1'b1;
                    st_nxt  = sync2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == LAST) begin
                    cnt_rst  = 1'b1;
                    do_shift = 1'b1;
                    if (bit_idx == 3'd7) st_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt == LAST) begin
                    st_nxt = ST_IDLE;
                    vld_d  = sync2;
                    err_d  = !sync2;
                end
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            st       <= ST_IDLE;
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            prev     <= 1'b1;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            byte_vld <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            st       <= st_nxt;
            sync1    <= rx;
            sync2    <= sync1;
            prev     <= sync2;
            cnt      <= cnt_rst ? '0 : cnt + 1'b1;
            byte_vld <= vld_d;
            frm_err  <= err_d;
            if (st == ST_START) bit_idx <= '0;
            if (do_shift) begin
                shreg   <= {sync2, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/cfg_master.sv
// Config link host stand-in: sends 3-byte command frames on TX_C, assembles
// the 2-byte core response from RX_C.
module cfg_master
    import cfg_pkg::*;
#(
    parameter int BIT_CLKS = BIT_CLKS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] cmd_data,
    input  logic        snd_frm,
    output logic        TX_C,
    input  logic        RX_C,
    output logic [15:0] resp,
    output logic        rsp_rdy
);

    localparam int            CW   = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);

    uart_st_e      tx_st, tx_nxt;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [1:0]    tx_byte;
    logic [23:0]   cmd_lat;
    logic [7:0]    cur_byte;
    logic          accept, tx_tick, cnt_rst, bit_inc, byte_inc;

    logic [7:0]    rx_data;
    logic          byte_vld, frm_err, rx_idx;
    logic [7:0]    resp_hi;

    assign accept  = (tx_st == ST_IDLE) && snd_frm;
    assign tx_tick = (tx_cnt == LAST);

    always_comb begin
        case (tx_byte)
            2'd0:    cur_byte = cmd_lat[CMD_HI:CMD_LO];
            2'd1:    cur_byte = cmd_lat[15:8];
            default: cur_byte = cmd_lat[7:0];
        endcase
    end

    always_comb begin
        tx_nxt   = tx_st;
        cnt_rst  = 1'b0;
        bit_inc  = 1'b0;
        byte_inc = 1'b0;
        TX_C     = 1'b1;
        case (tx_st)
            ST_IDLE: begin
                cnt_rst = 1'b1;
                if (snd_frm) tx_nxt = ST_START;
            end
            ST_START: begin
                TX_C = 1'b0;
                if (tx_tick) begin
                    cnt_rst = 1'b1;
                    tx_nxt  = ST_DATA;
                end
            end
            ST_DATA: begin
                TX_C = cur_byte[tx_bit];
                if (tx_tick) begin
                    cnt_rst = 1'b1;
                    bit_inc = 1'b1;
                    if (tx_bit == 3'd7) tx_nxt = ST_STOP;
                end
            end
            // Bytes run back-to-back: STOP goes straight into the next START.
            ST_STOP: begin
                if (tx_tick) begin
                    cnt_rst = 1'b1;
                    if (tx_byte == 2'd2) begin
                        tx_nxt = ST_IDLE;
                    end else begin
                        byte_inc = 1'b1;
                        tx_nxt   = ST_START;
                    end
                end
            end
            default: tx_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            tx_st   <= ST_IDLE;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_byte <= '0;
            cmd_lat <= '0;
        end else begin
            tx_st  <= tx_nxt;
            tx_cnt <= cnt_rst ? '0 : tx_cnt + 1'b1;
            if (bit_inc)  tx_bit  <= tx_bit + 3'd1;
            if (byte_inc) tx_byte <= tx_byte + 2'd1;
            if (accept) begin
                cmd_lat <= cmd_data;
                tx_bit  <= '0;
                tx_byte <= '0;
            end
        end
    end

    cfg_uart_rx_byte #(.BIT_CLKS(BIT_CLKS)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (RX_C),
        .rx_data  (rx_data),
        .byte_vld (byte_vld),
        .frm_err  (frm_err)
    );

    // A new command restarts response assembly; a framing error drops any half word.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rx_idx  <= 1'b0;
            resp_hi <= '0;
            resp    <= '0;
            rsp_rdy <= 1'b0;
        end else if (accept) begin
            rx_idx  <= 1'b0;
            rsp_rdy <= 1'b0;
        end else if (frm_err) begin
            rx_idx  <= 1'b0;
        end else if (byte_vld) begin
            if (!rx_idx) begin
                resp_hi <= rx_data;
                rx_idx  <= 1'b1;
            end else begin
                resp    <= {resp_hi, rx_data};
                rsp_rdy <= 1'b1;
                rx_idx  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cfg_master.sv
// Directed + randomized bench for cfg_master with a frame-level reference model.
module tb_cfg_master;

    localparam int BC = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] cmd_data = '0;
    logic        snd_frm = 1'b0;
    logic        TX_C;
    logic        RX_C = 1'b1;
    logic [15:0] resp;
    logic        rsp_rdy;

    int tests = 0;
    int fails = 0;

    // reference model of the response side
    int          m_idx  = 0;
    logic [7:0]  m_hi   = '0;
    logic [15:0] m_resp = '0;
    logic        m_rdy  = 1'b0;

    always #5 clk = ~clk;

    cfg_master #(.BIT_CLKS(BC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_data (cmd_data),
        .snd_frm  (snd_frm),
        .TX_C     (TX_C),
        .RX_C     (RX_C),
        .resp     (resp),
        .rsp_rdy  (rsp_rdy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level at cycle i of a 3-byte 8N1 frame.
    function automatic logic exp_tx(input logic [23:0] d, input int i);
        int         b = i / BC;
        int         k = b / 10;
        int         p = b % 10;
        logic [7:0] by;
        by = 8'(d >> (16 - 8 * k));
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return by[3'(p - 1)];
    endfunction

    // Sends one frame and checks every cycle of it plus an idle tail.
    // inj_at: cycle to pulse a busy snd_frm; rst_at: cycle to assert reset.
    task automatic tx_frame(input string tag, input logic [23:0] d, input int inj_at, input int rst_at);
        int   mism = 0;
        int   first = -1;
        logic e;
        @(negedge clk);
        cmd_data = d;
        snd_frm  = 1'b1;
        @(negedge clk);
        snd_frm = 1'b0;
        m_idx = 0;
        m_rdy = 1'b0;
        check({tag, "_rdy_clr"}, 32'(rsp_rdy), 0);
        for (int i = 0; i < 30 * BC + 200; i++) begin
            if (i > 0) @(negedge clk);
            if (i >= 30 * BC || (rst_at >= 0 && i > rst_at)) e = 1'b1;
            else e = exp_tx(d, i);
            if (TX_C !== e) begin
                mism++;
                if (first < 0) first = i;
            end
            if (i == inj_at) begin
                cmd_data = 24'hFFFFFF;
                snd_frm  = 1'b1;
            end
            if (i == inj_at + 1) snd_frm = 1'b0;
            if (i == rst_at) rst_n = 1'b1;
            if (i == rst_at + 1) rst_n = 1'b0;
        end
        if (rst_at >= 0) begin
            m_idx = 0; m_hi = '0; m_resp = '0; m_rdy = 1'b0;
        end
        if (mism != 0) $display("[TB] %s: first bad TX_C cycle %0d", tag, first);
        check({tag, "_tx_bits"}, mism, 0);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        RX_C = 1'b0;
        repeat (BC) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            RX_C = b[k];
            repeat (BC) @(negedge clk);
        end
        RX_C = stop;
        repeat (BC) @(negedge clk);
        if (!stop) begin
            RX_C = 1'b1;
            repeat (BC) @(negedge clk);
            m_idx = 0;
        end else if (m_idx == 0) begin
            m_hi  = b;
            m_idx = 1;
        end else begin
            m_resp = {m_hi, b};
            m_rdy  = 1'b1;
            m_idx  = 0;
        end
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_resp"}, 32'(resp), 32'(m_resp));
        check({tag, "_rdy"}, 32'(rsp_rdy), 32'(m_rdy));
    endtask

    initial begin
        int          idle_bad;
        logic [7:0]  a, b;
        logic [15:0] held;

        // reset
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        check("rst_tx", 32'(TX_C), 1);
        check("rst_resp", 32'(resp), 0);
        check("rst_rdy", 32'(rsp_rdy), 0);
        idle_bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (TX_C !== 1'b1) idle_bad++;
        end
        check("idle_tx", idle_bad, 0);

        // directed frame
        tx_frame("frm_a51234", 24'hA51234, -1, -1);

        // directed POSACK response
        rx_send(8'h0A, 1'b1);
        check_rx("ack_b0");
        rx_send(8'h5A, 1'b1);
        check_rx("ack_b1");
        check("ack_const", 32'(resp), 32'(cfg_pkg::POSACK));

        // new responses while rsp_rdy already set
        rx_send(cfg_pkg::NEGACK[15:8], 1'b1);
        rx_send(cfg_pkg::NEGACK[7:0], 1'b1);
        check_rx("nak");
        for (int n = 0; n < 2; n++) begin
            rx_send(8'($urandom), 1'b1);
            rx_send(8'($urandom), 1'b1);
            check_rx("rnd_rsp");
        end

        // snd_frm clears rsp_rdy, resp holds
        held = resp;
        tx_frame("frm_rnd0", 24'($urandom), -1, -1);
        check("resp_hold", 32'(resp), 32'(held));
        check_rx("after_frm");

        // partial response discarded by a new command
        rx_send(8'($urandom), 1'b1);
        tx_frame("frm_rnd1", 24'($urandom), -1, -1);
        a = 8'($urandom);
        b = 8'($urandom);
        rx_send(a, 1'b1);
        rx_send(b, 1'b1);
        check("partial_drop", 32'(resp), 32'({a, b}));
        check_rx("partial");

        // busy ignore
        tx_frame("frm_busy", 24'h000000, 100, -1);

        // 5-cycle glitch gives nothing
        held = resp;
        RX_C = 1'b0;
        repeat (5) @(negedge clk);
        RX_C = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_resp", 32'(resp), 32'(held));
        check_rx("glitch");

        // framing error resets byte index
        rx_send(8'h33, 1'b1);
        rx_send(8'h05, 1'b0);
        rx_send(8'h0A, 1'b1);
        rx_send(8'h5A, 1'b1);
        check("ferr_resp", 32'(resp), 32'h0A5A);
        check_rx("ferr");

        // random stop-bit mix against model
        for (int n = 0; n < 6; n++) begin
            rx_send(8'($urandom), 1'($urandom_range(0, 3) != 0));
            check_rx("rnd_ferr");
        end

        tx_frame("frm_rnd2", 24'($urandom), -1, -1);

        // mid-frame reset
        rx_send(8'($urandom), 1'b1);
        rx_send(8'($urandom), 1'b1);
        tx_frame("frm_rst", 24'hC3A55A, -1, 200);
        check("mrst_resp", 32'(resp), 0);
        check("mrst_rdy", 32'(rsp_rdy), 0);
        check("mrst_tx", 32'(TX_C), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
